mcp23s17_joy_bridge: RTL and testbench

- SPI master that polls an MCP23S17 GPIO expander wired to the Megadrive DB9 port.
- Presents the six DB9 input pins as `joy_in[5:0]` (CBUDLR, raw active-low pin levels) to the downstream DB9 Megadrive decoder.
- Forwards that decoder's select output (`joy_mdsel`) to the expander's pin 7 driver.
- Runs an init sequence after reset, then loops forever: write the select pin when it has changed, then read the input port.

---
 rtl/mcp23s17_joy_bridge.sv | 198 +++++++++++++++++++
 tb/tb_mcp23s17_joy_bridge.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/mcp23s17_joy_bridge.sv
// SPI bridge between an MCP23S17 GPIO expander on the Megadrive DB9 port and
// the downstream DB9 decoder. After reset it configures the expander (port A
// inputs with pull-ups, GPB0 output carrying the select line), then polls
// GPIOA forever, writing OLATB first whenever the requested select level has
// changed since the last write.
//
// Frame engine: every frame uses 50*CLK_DIV clocks, counted as 24 bit slots of
// 2*CLK_DIV clocks (SCK low half, then SCK high half), one CLK_DIV tail slot
// with CS still low, and one CLK_DIV gap slot with CS high. Frames that return
// to POLL_CHK end their gap one clock early so the POLL_CHK cycle fills it and
// the frame period stays 50*CLK_DIV. SPI pins are registered and so trail the
// counters by one clock.
module mcp23s17_joy_bridge #(
  parameter int         CLK_DIV  = 4,
  parameter logic [2:0] DEV_ADDR = 3'b000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       joy_mdsel,
  output logic [5:0] joy_in,
  output logic       joy_valid,
  output logic       ready,
  output logic       spi_cs_n,
  output logic       spi_sck,
  output logic       spi_mosi,
  input  logic       spi_miso
);

  localparam int              DIV_W     = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_SHORT = DIV_W'(CLK_DIV - 2);
  localparam logic [7:0]      OP_WR     = {4'b0100, DEV_ADDR, 1'b0};
  localparam logic [7:0]      OP_RD     = {4'b0100, DEV_ADDR, 1'b1};
  localparam logic [23:0]     WORD_IODIRA = {OP_WR, 8'h00, 8'hFF};
  localparam logic [23:0]     WORD_GPPUA  = {OP_WR, 8'h0C, 8'h3F};
  localparam logic [23:0]     WORD_IODIRB = {OP_WR, 8'h01, 8'hFE};
  localparam logic [23:0]     WORD_RD_IN  = {OP_RD, 8'h12, 8'h00};
  localparam logic [4:0]      BIT_TAIL  = 5'd24;
  localparam logic [4:0]      BIT_GAP   = 5'd25;

  typedef enum logic [2:0] {
    S_INIT_A,
    S_INIT_PU,
    S_INIT_OL,
    S_INIT_B,
    S_POLL_CHK,
    S_WR_SEL,
    S_RD_IN
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [DIV_W-1:0] r_div;
  logic             r_hi;
  logic [4:0]       r_bit;
  logic [23:0]      r_shift;
  logic [5:0]       r_rx;
  logic             r_cs_n;
  logic             r_sck;
  logic             r_mosi;
  logic [5:0]       r_joy_in;
  logic             r_valid;
  logic             r_ready;
  logic             r_mdsel_last;

  logic             w_in_frame;
  logic             w_short;
  logic             w_frame_end;
  logic             w_load;
  logic [23:0]      w_word;
  logic             w_cs_n_next;
  logic             w_sck_next;
  logic             w_mosi_next;
  logic             w_sample;
  logic             w_rd_done;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_INIT_A;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic: frame states advance on the last clock of their frame.
  always_comb begin
    w_in_frame   = (r_state != S_POLL_CHK);
    w_short      = (r_state == S_INIT_B) || (r_state == S_RD_IN);
    w_frame_end  = w_in_frame && (r_bit == BIT_GAP) &&
                   (r_div == (w_short ? DIV_SHORT : DIV_LAST));
    w_state_next = r_state;
    case (r_state)
      S_INIT_A:   if (w_frame_end) w_state_next = S_INIT_PU;
      S_INIT_PU:  if (w_frame_end) w_state_next = S_INIT_OL;
      S_INIT_OL:  if (w_frame_end) w_state_next = S_INIT_B;
      S_INIT_B:   if (w_frame_end) w_state_next = S_POLL_CHK;
      S_POLL_CHK: w_state_next = (joy_mdsel != r_mdsel_last) ? S_WR_SEL : S_RD_IN;
      S_WR_SEL:   if (w_frame_end) w_state_next = S_RD_IN;
      S_RD_IN:    if (w_frame_end) w_state_next = S_POLL_CHK;
      default:    w_state_next = S_INIT_A;
    endcase
  end

  // Output decode: frame word to load and next values of the SPI pins.
  always_comb begin
    w_load = (w_state_next != r_state) && (w_state_next != S_POLL_CHK);
    case (w_state_next)
      S_INIT_A:  w_word = WORD_IODIRA;
      S_INIT_PU: w_word = WORD_GPPUA;
      S_INIT_OL: w_word = {OP_WR, 8'h15, 7'b0, joy_mdsel};
      S_INIT_B:  w_word = WORD_IODIRB;
      S_WR_SEL:  w_word = {OP_WR, 8'h15, 7'b0, joy_mdsel};
      default:   w_word = WORD_RD_IN;
    endcase
    w_cs_n_next = !(w_in_frame && (r_bit < BIT_GAP));
    w_sck_next  = w_in_frame && r_hi;
    w_mosi_next = w_in_frame && (r_bit < BIT_TAIL) && r_shift[23];
    // MISO is captured on the clock edge that raises SCK.
    w_sample    = w_in_frame && r_hi && (r_div == '0);
    // The first gap clock of a read: CS rises on this edge.
    w_rd_done   = (r_state == S_RD_IN) && (r_bit == BIT_GAP) && (r_div == '0);
  end

  // Bit-slot counters and the outgoing shift register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_div   <= '0;
      r_hi    <= 1'b0;
      r_bit   <= '0;
      r_shift <= WORD_IODIRA;
    end else if (w_load || w_frame_end) begin
      r_div <= '0;
      r_hi  <= 1'b0;
      r_bit <= '0;
      if (w_load) begin
        r_shift <= w_word;
      end
    end else if (w_in_frame) begin
      if (r_div == DIV_LAST) begin
        r_div <= '0;
        if (r_bit < BIT_TAIL) begin
          if (r_hi) begin
            r_hi    <= 1'b0;
            r_bit   <= 5'(r_bit + 5'd1);
            r_shift <= {r_shift[22:0], 1'b0};
          end else begin
            r_hi <= 1'b1;
          end
        end else if (r_bit == BIT_TAIL) begin
          r_bit <= BIT_GAP;
        end
      end else begin
        r_div <= DIV_W'(r_div + DIV_W'(1));
      end
    end
  end

  // Registered pins, receive shifter, joystick result, ready and select latch.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cs_n       <= 1'b1;
      r_sck        <= 1'b0;
      r_mosi       <= 1'b0;
      r_rx         <= 6'h3F;
      r_joy_in     <= 6'h3F;
      r_valid      <= 1'b0;
      r_ready      <= 1'b0;
      r_mdsel_last <= 1'b1;
    end else begin
      r_cs_n  <= w_cs_n_next;
      r_sck   <= w_sck_next;
      r_mosi  <= w_mosi_next;
      r_valid <= w_rd_done;
      // Only the last six bits of a read (GPIOA[5:0]) are kept.
      if (w_sample) begin
        r_rx <= {r_rx[4:0], spi_miso};
      end
      if (w_rd_done) begin
        r_joy_in <= r_rx;
      end
      if ((r_state == S_INIT_B) && w_frame_end) begin
        r_ready <= 1'b1;
      end
      if (w_load && ((w_state_next == S_INIT_OL) || (w_state_next == S_WR_SEL))) begin
        r_mdsel_last <= joy_mdsel;
      end
    end
  end

  assign spi_cs_n  = r_cs_n;
  assign spi_sck   = r_sck;
  assign spi_mosi  = r_mosi;
  assign joy_in    = r_joy_in;
  assign joy_valid = r_valid;
  assign ready     = r_ready;

endmodule

// File: tb/tb_mcp23s17_joy_bridge.sv
// Directed bench for mcp23s17_joy_bridge. Instance 0 runs CLK_DIV=4,
// DEV_ADDR=0; instance 1 runs CLK_DIV=2, DEV_ADDR=5. Each instance has a
// frame monitor and a small MCP23S17 read model on MISO.
module tb_mcp23s17_joy_bridge;

  localparam logic [23:0] INIT_W0 [4] = '{24'h4000FF, 24'h400C3F, 24'h401501, 24'h4001FE};
  localparam logic [23:0] INIT_W1 [4] = '{24'h4A00FF, 24'h4A0C3F, 24'h4A1501, 24'h4A01FE};

  logic       clk = 1'b0;
  logic       rst_v   [2];
  logic       mdsel_v [2];
  logic [7:0] gpio_a = 8'hEA;
  int         tests = 0;
  int         fails = 0;

  always #5 clk = ~clk;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
      logic       cs_n, sck, mosi, valid, ready;
      logic       miso = 1'b0;
      logic [5:0] joy;

      mcp23s17_joy_bridge #(
        .CLK_DIV  ((gi == 0) ? 4 : 2),
        .DEV_ADDR ((gi == 0) ? 3'b000 : 3'b101)
      ) u_dut (
        .clk       (clk),
        .reset     (rst_v[gi]),
        .joy_mdsel (mdsel_v[gi]),
        .joy_in    (joy),
        .joy_valid (valid),
        .ready     (ready),
        .spi_cs_n  (cs_n),
        .spi_sck   (sck),
        .spi_mosi  (mosi),
        .spi_miso  (miso)
      );

      logic [23:0] frm_word [$];
      int          frm_len  [$];
      int          frm_bits [$];
      int          frm_per  [$];
      int          frm_rdy  [$];
      logic [7:0]  sent     [$];
      logic [5:0]  rx       [$];
      logic        prev_cs = 1'b1, prev_sck = 1'b0, prev_mosi = 1'b0;
      logic [5:0]  prev_joy = 6'h3F;
      logic [23:0] word = '0, tx = '0;
      int cs_cnt = 0, bits = 0, cyc = 0, last_start = 0, nstart = 0, nvalid = 0, idx = -1;
      int bad_mosi = 0, bad_idle = 0, bad_joy = 0;

      // GPIOA byte the model returns in frame n.
      function automatic logic [7:0] model_byte(input int n);
        return (gi == 0) ? gpio_a : 8'(32'h5C + 41 * n);
      endfunction

      // Frame monitor and MISO model, sampled on the falling clock edge.
      always @(negedge clk) begin
        cyc       <= cyc + 1;
        prev_cs   <= cs_n;
        prev_sck  <= sck;
        prev_mosi <= mosi;
        prev_joy  <= joy;
        if (!cs_n && prev_cs) begin
          cs_cnt     <= 1;
          bits       <= 0;
          word       <= '0;
          nstart     <= nstart + 1;
          last_start <= cyc;
          frm_per.push_back(cyc - last_start);
          sent.push_back(model_byte(nstart));
          tx   <= {16'h0000, model_byte(nstart)};
          miso <= 1'b0;
          idx  <= 22;
        end else if (!cs_n) begin
          cs_cnt <= cs_cnt + 1;
          if (sck && !prev_sck) begin
            word <= {word[22:0], mosi};
            bits <= bits + 1;
            if (mosi !== prev_mosi) bad_mosi <= bad_mosi + 1;
          end
          if (!sck && prev_sck && idx >= 0) begin
            miso <= tx[5'(idx)];
            idx  <= idx - 1;
          end
        end
        if (cs_n && !prev_cs) begin
          frm_word.push_back(word);
          frm_len.push_back(cs_cnt);
          frm_bits.push_back(bits);
          frm_rdy.push_back(int'(ready));
        end
        if (cs_n && sck) bad_idle <= bad_idle + 1;
        if (valid) begin
          nvalid <= nvalid + 1;
          rx.push_back(joy);
        end
        if ((joy !== prev_joy) && !valid && !rst_v[gi]) bad_joy <= bad_joy + 1;
      end
    end
  endgenerate

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_frames(input int sel, input int n);
    int t = 0;
    int sz = 0;
    while (t < 4000) begin
      sz = (sel == 0) ? g_dut[0].frm_word.size() : g_dut[1].frm_word.size();
      if (sz >= n) break;
      @(negedge clk);
      t++;
    end
    chk($sformatf("wait_frames%0d_%0d", sel, n), 32'(sz >= n), 1);
  endtask

  initial begin
    int t;
    rst_v[0]   = 1'b1;
    rst_v[1]   = 1'b1;
    mdsel_v[0] = 1'b1;
    mdsel_v[1] = 1'b1;
    repeat (4) @(negedge clk);
    chk("rst_cs_n", 32'(g_dut[0].cs_n), 1);
    chk("rst_sck", 32'(g_dut[0].sck), 0);
    chk("rst_mosi", 32'(g_dut[0].mosi), 0);
    chk("rst_joy", 32'(g_dut[0].joy), 32'h3F);
    chk("rst_valid", 32'(g_dut[0].valid), 0);
    chk("rst_ready", 32'(g_dut[0].ready), 0);
    chk("rst_cs_n_b", 32'(g_dut[1].cs_n), 1);
    rst_v[0] = 1'b0;
    rst_v[1] = 1'b0;

    // Init frames on instance 0.
    wait_frames(0, 4);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("init_word[%0d]", k), 32'(g_dut[0].frm_word[k]), 32'(INIT_W0[k]));
      chk($sformatf("init_len[%0d]", k), g_dut[0].frm_len[k], 196);
      chk($sformatf("init_bits[%0d]", k), g_dut[0].frm_bits[k], 24);
      if (k > 0) chk($sformatf("init_per[%0d]", k), g_dut[0].frm_per[k], 200);
    end
    chk("ready_at_init_b_end", g_dut[0].frm_rdy[3], 0);
    repeat (6) @(negedge clk);
    chk("ready_after_init", 32'(g_dut[0].ready), 1);

    // First read, GPIOA = 0xEA.
    wait_frames(0, 5);
    @(negedge clk);
    chk("rd_word[4]", 32'(g_dut[0].frm_word[4]), 32'h411200);
    chk("rd_per[4]", g_dut[0].frm_per[4], 200);
    chk("rd_joy_2a", 32'(g_dut[0].joy), 32'h2A);
    chk("rd_nvalid_1", g_dut[0].nvalid, 1);
    gpio_a = 8'hD5;

    // Select toggles 1->0 in the middle of read frame 5.
    t = 0;
    while (g_dut[0].nstart < 6 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    chk("start_frame5", 32'(g_dut[0].nstart >= 6), 1);
    repeat (60) @(negedge clk);
    mdsel_v[0] = 1'b0;
    wait_frames(0, 9);
    @(negedge clk);
    chk("sel_word[5]", 32'(g_dut[0].frm_word[5]), 32'h411200);
    chk("sel_word[6]", 32'(g_dut[0].frm_word[6]), 32'h401500);
    chk("sel_word[7]", 32'(g_dut[0].frm_word[7]), 32'h411200);
    chk("sel_word[8]", 32'(g_dut[0].frm_word[8]), 32'h411200);
    for (int k = 5; k < 9; k++) begin
      chk($sformatf("sel_per[%0d]", k), g_dut[0].frm_per[k], 200);
    end
    chk("sel_joy_15", 32'(g_dut[0].joy), 32'h15);
    chk("sel_nvalid_4", g_dut[0].nvalid, 4);

    // Reset around bit 10 of read frame 9.
    t = 0;
    while (!(g_dut[0].nstart >= 10 && g_dut[0].bits >= 10) && t < 1000) begin
      @(negedge clk);
      t++;
    end
    chk("reach_bit10", 32'(g_dut[0].bits >= 10), 1);
    rst_v[0] = 1'b1;
    @(negedge clk);
    chk("mid_rst_cs_n", 32'(g_dut[0].cs_n), 1);
    chk("mid_rst_sck", 32'(g_dut[0].sck), 0);
    chk("mid_rst_joy", 32'(g_dut[0].joy), 32'h3F);
    chk("mid_rst_ready", 32'(g_dut[0].ready), 0);
    repeat (3) @(negedge clk);
    rst_v[0] = 1'b0;
    wait_frames(0, 11);
    chk("abort_bits_short", 32'(g_dut[0].frm_bits[9] < 24), 1);
    chk("restart_word", 32'(g_dut[0].frm_word[10]), 32'h4000FF);
    chk("restart_len", g_dut[0].frm_len[10], 196);

    // Instance 1: DEV_ADDR=5, CLK_DIV=2, changing GPIOA every frame.
    wait_frames(1, 10);
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("b_word[%0d]", k), 32'(g_dut[1].frm_word[k]),
          (k < 4) ? 32'(INIT_W1[k]) : 32'h4B1200);
      chk($sformatf("b_len[%0d]", k), g_dut[1].frm_len[k], 98);
      if (k > 0) chk($sformatf("b_per[%0d]", k), g_dut[1].frm_per[k], 100);
      if (k >= 4) chk($sformatf("b_joy[%0d]", k), 32'(g_dut[1].rx[k-4]),
                      32'(g_dut[1].sent[k][5:0]));
    end
    chk("b_ready", 32'(g_dut[1].ready), 1);

    for (int i = 0; i < 2; i++) begin
      chk($sformatf("mosi_stable%0d", i), (i == 0) ? g_dut[0].bad_mosi : g_dut[1].bad_mosi, 0);
      chk($sformatf("sck_idle%0d", i), (i == 0) ? g_dut[0].bad_idle : g_dut[1].bad_idle, 0);
      chk($sformatf("joy_only_on_valid%0d", i), (i == 0) ? g_dut[0].bad_joy : g_dut[1].bad_joy, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Watchdog so the bench always ends.
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
